iter_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/iter_muldiv.sv | 92 +++++++++
 rtl/iter_alu.sv | 118 +++++++++++
 tb/tb_iter_alu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state codes and op classification for the iterative ALU.
// No logic of its own; pure constants and a helper function.
// No flow control here; see iter_alu for the handshake.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLLI  = 4'd2;
  localparam logic [3:0] ALU_SRLI  = 4'd3;
  localparam logic [3:0] ALU_SLL   = 4'd4;
  localparam logic [3:0] ALU_SRL   = 4'd5;
  localparam logic [3:0] ALU_SRA   = 4'd6;
  localparam logic [3:0] ALU_AND   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_XOR   = 4'd9;
  localparam logic [3:0] ALU_XNOR  = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;
  localparam logic [3:0] ALU_MULHU = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_REMU  = 4'd14;
  localparam logic [3:0] ALU_SLT   = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Multiply/divide family runs through the bit-serial engine.
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiply (shift-add) and divide (restoring) engine.
// Latency: start cycle latches operands, then WL step cycles; done is high in the last one.
// No backpressure: the parent only starts it when idle and consumes result on done.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WL  = 32,
  parameter int SHW = $clog2(WL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic          done,
  output logic [WL-1:0] result
);

  // acc holds {hi, lo} of the product, or {remainder, quotient} while dividing.
  logic [2*WL-1:0] acc_q, acc_d;
  logic [WL-1:0]   opnd_q, opnd_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            div_q, div_d;
  logic            hi_q, hi_d;

  logic [WL:0]     mul_sum;
  logic [WL:0]     div_sh;
  logic [WL:0]     div_diff;
  logic [2*WL-1:0] step;
  logic            op_div;

  // One datapath step: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WL-1:WL]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = acc_q[2*WL-1:WL-1];
    div_diff = div_sh - {1'b0, opnd_q};
    if (div_q) begin
      // A divisor of zero never goes negative, which yields all-ones quotient and remainder = dividend.
      if (!div_diff[WL]) step = {div_diff[WL-1:0], acc_q[WL-2:0], 1'b1};
      else               step = {div_sh[WL-1:0], acc_q[WL-2:0], 1'b0};
    end else begin
      step = {mul_sum, acc_q[WL-1:1]};
    end
    done   = busy_q && (cnt_q == '0);
    result = hi_q ? step[2*WL-1:WL] : step[WL-1:0];
  end

  // Operand capture on start, then count WL-1 down to 0 applying one step per cycle.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    hi_d   = hi_q;
    op_div = (op == ALU_DIVU) || (op == ALU_REMU);
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = SHW'(WL - 1);
      div_d  = op_div;
      hi_d   = (op == ALU_MULHU) || (op == ALU_REMU);
      opnd_d = op_div ? b : a;
      acc_d  = {{WL{1'b0}}, (op_div ? a : b)};
    end else if (busy_q) begin
      acc_d = step;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  // Engine state registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: 12 single-cycle ops plus bit-serial MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle for simple ops, WL+1 cycles for multiply/divide, from the accept cycle.
// Result held in DONE until out_ready; in_ready is high only in IDLE, so no accept on the handshake cycle.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WL  = 32,
  parameter int SHW = $clog2(WL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     ALUsel,
  input  logic [WL-1:0]  ALUIn1,
  input  logic [WL-1:0]  ALUIn2,
  input  logic [SHW-1:0] shamt2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WL-1:0]  ALUOut,
  output logic           Zero
);

  logic [1:0]    state_q, state_d;
  logic [WL-1:0] alu_out_q, alu_out_d;
  logic          zero_q, zero_d;

  logic          accept;
  logic          md_start;
  logic          md_done;
  logic [WL-1:0] md_res;
  logic [WL-1:0] sc_res;
  logic [SHW-1:0] sh_a;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign ALUOut    = alu_out_q;
  assign Zero      = zero_q;
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_iterative(ALUsel);

  iter_muldiv #(.WL(WL), .SHW(SHW)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (ALUsel),
    .a      (ALUIn1),
    .b      (ALUIn2),
    .done   (md_done),
    .result (md_res)
  );

  // Single-cycle result straight from the request; it is registered on accept.
  always_comb begin
    sh_a   = ALUIn1[SHW-1:0];
    sc_res = '0;
    case (ALUsel)
      ALU_ADD:  sc_res = ALUIn1 + ALUIn2;
      ALU_SUB:  sc_res = ALUIn1 - ALUIn2;
      ALU_SLLI: sc_res = ALUIn2 << shamt2;
      ALU_SRLI: sc_res = ALUIn2 >> shamt2;
      ALU_SLL:  sc_res = ALUIn2 << sh_a;
      ALU_SRL:  sc_res = ALUIn2 >> sh_a;
      ALU_SRA:  sc_res = $signed(ALUIn2) >>> sh_a;
      ALU_AND:  sc_res = ALUIn1 & ALUIn2;
      ALU_OR:   sc_res = ALUIn1 | ALUIn2;
      ALU_XOR:  sc_res = ALUIn1 ^ ALUIn2;
      ALU_XNOR: sc_res = ~(ALUIn1 ^ ALUIn2);
      ALU_SLT:  sc_res = {{(WL-1){1'b0}}, ($signed(ALUIn1) < $signed(ALUIn2))};
      default:  sc_res = '0;
    endcase
  end

  // IDLE -> DONE (simple) or BUSY (mul/div) on accept; BUSY -> DONE on engine done; DONE -> IDLE on out_ready.
  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_iterative(ALUsel)) begin
            state_d = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            alu_out_d = sc_res;
            zero_d    = (sc_res == '0);
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d   = ST_DONE;
          alu_out_d = md_res;
          zero_d    = (md_res == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench: WL=32 directed + random, WL=16 random, against a 64-bit arithmetic model.
module tb_iter_alu;

  localparam int W   = 32;
  localparam int SW  = 5;
  localparam int W16 = 16;
  localparam int SW16 = 4;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WL=32 instance
  logic          in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]    sel;
  logic [W-1:0]  a, b, y;
  logic [SW-1:0] sh;

  // WL=16 instance
  logic            in_valid_s, in_ready_s, out_valid_s, out_ready_s, zero_s;
  logic [3:0]      sel_s;
  logic [W16-1:0]  a_s, b_s, y_s;
  logic [SW16-1:0] sh_s;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];
  exp_t exp16_q[$];
  exp_t e32, e16;
  logic prev_ov = 1'b0, prev_ov_s = 1'b0;
  logic [W-1:0] held_y, last_y;
  logic [W16-1:0] held_y_s;
  int last_lat;

  iter_alu #(.WL(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUsel(sel), .ALUIn1(a), .ALUIn2(b), .shamt2(sh),
    .out_valid(out_valid), .out_ready(out_ready), .ALUOut(y), .Zero(zero)
  );

  iter_alu #(.WL(W16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .ALUsel(sel_s), .ALUIn1(a_s), .ALUIn2(b_s), .shamt2(sh_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .ALUOut(y_s), .Zero(zero_s)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain wide-integer arithmetic at width w.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input int s_imm, input int w);
    logic [63:0] mask, ma, mb, r;
    logic signed [63:0] sa, sb;
    int s;
    mask = (64'd1 << w) - 64'd1;
    ma = a_in & mask;
    mb = b_in & mask;
    sa = ma[w-1] ? $signed(ma | ~mask) : $signed(ma);
    sb = mb[w-1] ? $signed(mb | ~mask) : $signed(mb);
    s  = int'(ma & 64'(w - 1));
    r  = '0;
    case (op)
      4'd0:  r = ma + mb;
      4'd1:  r = ma - mb;
      4'd2:  r = mb << s_imm;
      4'd3:  r = mb >> s_imm;
      4'd4:  r = mb << s;
      4'd5:  r = mb >> s;
      4'd6:  r = 64'(sb >>> s);
      4'd7:  r = ma & mb;
      4'd8:  r = ma | mb;
      4'd9:  r = ma ^ mb;
      4'd10: r = ~(ma ^ mb);
      4'd11: r = ma * mb;
      4'd12: r = (ma * mb) >> w;
      4'd13: r = (mb == 0) ? mask : ma / mb;
      4'd14: r = (mb == 0) ? ma : ma % mb;
      default: r = (sa < sb) ? 64'd1 : 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic int lat_of(input logic [3:0] op, input int w);
    return (op >= 4'd11 && op <= 4'd14) ? w + 1 : 1;
  endfunction

  // Compare process, WL=32: result, Zero, latency on first valid cycle; stability and in_ready while held.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e32 = exp_q.pop_front();
            last_y   = y;
            last_lat = cyc - e32.acc;
            chk("result", y, e32.res);
            chk("zero", zero, e32.res == 0);
            chk("latency", last_lat, e32.lat);
          end
          held_y = y;
        end else begin
          chk("held_result", y, held_y);
        end
      end
      prev_ov = out_valid;
    end
  end

  // Compare process, WL=16.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov_s = 1'b0;
    end else begin
      if (out_valid_s) begin
        chk("in_ready_in_done16", in_ready_s, 0);
        if (!prev_ov_s) begin
          if (exp16_q.size() == 0) begin
            chk("unexpected_result16", 1, 0);
          end else begin
            e16 = exp16_q.pop_front();
            chk("result16", y_s, e16.res);
            chk("zero16", zero_s, e16.res == 0);
            chk("latency16", cyc - e16.acc, e16.lat);
          end
          held_y_s = y_s;
        end else begin
          chk("held_result16", y_s, held_y_s);
        end
      end
      prev_ov_s = out_valid_s;
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [SW-1:0] ish);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    sel = op; a = ia; b = ib; sh = ish; in_valid = 1'b1;
    exp_q.push_back('{model(op, 64'(ia), 64'(ib), int'(ish), W), lat_of(op, W), cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the result with a pending (ignored) request on the inputs, holds it 'hold' cycles, then consumes.
  task automatic finish_txn(input int hold);
    int n = 0;
    sel = 4'($urandom); a = $urandom; b = $urandom; sh = 5'($urandom); in_valid = 1'b1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("result_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handshake", in_ready, 1);
    chk("out_valid_dropped", out_valid, 0);
  endtask

  task automatic txn(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [SW-1:0] ish, input int hold);
    send(op, ia, ib, ish);
    finish_txn(hold);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    logic [W-1:0] ra, rb;
    int n;

    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; sel = 0; a = 0; b = 0; sh = 0;
    in_valid_s = 0; out_ready_s = 0; sel_s = 0; a_s = 0; b_s = 0; sh_s = 0;

    // Pin the model against hand-computed values.
    chk("pin_add", model(4'd0, 64'd5, 64'd7, 0, 32), 64'd12);
    chk("pin_sra", model(4'd6, 64'd4, 64'h80000000, 0, 32), 64'hF8000000);
    chk("pin_mul", model(4'd11, 64'hFFFFFFFF, 64'd2, 0, 32), 64'hFFFFFFFE);
    chk("pin_mulhu", model(4'd12, 64'hFFFFFFFF, 64'd2, 0, 32), 64'd1);
    chk("pin_divu0", model(4'd13, 64'd100, 64'd0, 0, 32), 64'hFFFFFFFF);
    chk("pin_slt", model(4'd15, 64'hFFFFFFFF, 64'd1, 0, 32), 64'd1);
    chk("pin16_mulhu", model(4'd12, 64'hFFFF, 64'hFFFF, 0, 16), 64'hFFFE);
    chk("pin16_sra", model(4'd6, 64'd3, 64'h8000, 0, 16), 64'hF000);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aluout", y, 0);
    chk("rst_zero", zero, 1);
    chk("rst16_in_ready", in_ready_s, 1);
    chk("rst16_zero", zero_s, 1);
    rst_n = 1'b1;

    // Reset in the middle of a multiply: no result, back to reset values.
    send(4'd11, 32'h12345678, 32'h9ABCDEF0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_aluout", y, 0);
    chk("midrst_zero", zero, 1);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);
    txn(4'd0, 32'd5, 32'd7, 0, 0);
    chk("add_5_7", last_y, 12);
    chk("add_latency", last_lat, 1);

    txn(4'd1, 32'd3, 32'd3, 0, 0);
    chk("sub_3_3", last_y, 0);
    txn(4'd6, 32'd4, 32'h80000000, 0, 0);
    chk("sra_80000000_4", last_y, 32'hF8000000);

    txn(4'd11, 32'hFFFFFFFF, 32'd2, 0, 0);
    chk("mul_lo", last_y, 32'hFFFFFFFE);
    chk("mul_latency", last_lat, 33);
    txn(4'd12, 32'hFFFFFFFF, 32'd2, 0, 0);
    chk("mulhu", last_y, 1);

    txn(4'd13, 32'd100, 32'd7, 0, 0);
    chk("divu_100_7", last_y, 14);
    txn(4'd14, 32'd100, 32'd7, 0, 0);
    chk("remu_100_7", last_y, 2);
    txn(4'd13, 32'd100, 32'd0, 0, 0);
    chk("divu_by_0", last_y, 32'hFFFFFFFF);
    txn(4'd14, 32'd100, 32'd0, 0, 0);
    chk("remu_by_0", last_y, 100);

    // Backpressure: result held 5 cycles with a competing request on the inputs.
    txn(4'd8, 32'h0F0F0000, 32'h000000F0, 0, 5);
    chk("or_held", last_y, 32'h0F0F00F0);

    txn(4'd15, 32'hFFFFFFFF, 32'd1, 0, 0);
    chk("slt_m1_1", last_y, 1);
    txn(4'd15, 32'd1, 32'hFFFFFFFF, 0, 0);
    chk("slt_1_m1", last_y, 0);
    txn(4'd2, 32'hDEAD, 32'h00000003, 5'd31, 1);
    chk("slli_31", last_y, 32'h80000000);

    // Random ops, WL=32.
    for (int t = 0; t < 120; t++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      txn(op, ra, rb, 5'($urandom), $urandom_range(0, 2));
    end

    // Random ops, WL=16, with random consumer stalls.
    for (int t = 0; t < 150; t++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready_s && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready_s) chk("in_ready16_timeout", 0, 1);
      sel_s = 4'($urandom_range(0, 15));
      a_s   = 16'($urandom);
      b_s   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      sh_s  = 4'($urandom);
      in_valid_s = 1'b1;
      exp16_q.push_back('{model(sel_s, 64'(a_s), 64'(b_s), int'(sh_s), W16), lat_of(sel_s, W16), cyc});
      @(negedge clk);
      in_valid_s = 1'b0;
      n = 0;
      while ((exp16_q.size() != 0 || out_valid_s) && n < 100) begin
        out_ready_s = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      out_ready_s = 1'b0;
      if (n >= 100) chk("drain16_timeout", 0, 1);
    end

    repeat (3) @(negedge clk);
    chk("queue32_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
